// File: rtl/rx_ram_read_scheduler_pkg.sv
// Shared types and widths for the receive-RAM read scheduler.
package rx_sched_pkg;
  localparam int RX_ADDR_W = 8;
  localparam int RX_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_CAP  = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_STREAM = 1'b0,
    GRANT_PEEK   = 1'b1
  } grant_t;
endpackage

// File: rtl/rx_ram_read_scheduler_if.sv
// Stream (tx) and random-access peek ports between the scheduler and its consumers.
interface rx_sched_if #(
  parameter int ADDR_W = rx_sched_pkg::RX_ADDR_W,
  parameter int DATA_W = rx_sched_pkg::RX_DATA_W
);
  // Stream: a byte moves when tx_valid && tx_ready at posedge; tx_valid and
  // tx_data hold until then. Peek: peek_req is a level held with a stable
  // peek_addr until peek_done pulses for one cycle with peek_data valid.
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              peek_req;
  logic [ADDR_W-1:0] peek_addr;
  logic [DATA_W-1:0] peek_data;
  logic              peek_done;

  modport master (
    output tx_data, tx_valid, peek_data, peek_done,
    input  tx_ready, peek_req, peek_addr
  );

  modport slave (
    input  tx_data, tx_valid, peek_data, peek_done,
    output tx_ready, peek_req, peek_addr
  );
endinterface

// File: rtl/rx_ram_read_scheduler_ptr_stabilizer.sv
// Captures the slow write pointer and only accepts it once two samples agree.
module ptr_stabilizer
  import rx_sched_pkg::*;
#(
  parameter int ADDR_W = RX_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] wr_stable
);
  logic [ADDR_W-1:0] wr_q1;
  logic [ADDR_W-1:0] wr_q2;

  // A multibit pointer mid-change never matches across two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q1     <= '0;
      wr_q2     <= '0;
      wr_stable <= '0;
    end else begin
      wr_q1 <= wr_ptr;
      wr_q2 <= wr_q1;
      if (wr_q1 == wr_q2) wr_stable <= wr_q2;
    end
  end
endmodule

// File: rtl/rx_ram_read_scheduler.sv
// Read-port owner of the receive RAM: drains unread bytes to the tx stream and
// interleaves random-access peeks, alternating grants on a tie.
module rx_ram_read_scheduler
  import rx_sched_pkg::*;
#(
  parameter int ADDR_W     = RX_ADDR_W,
  parameter int DATA_W     = RX_DATA_W,
  parameter int HIGH_WATER = 192
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] level,
  output logic              near_full,
  output state_t            state,
  output logic [ADDR_W-1:0] rd_ptr,
  rx_sched_if.master        bus
);
  localparam logic [ADDR_W-1:0] HW = HIGH_WATER[ADDR_W-1:0];

  logic [ADDR_W-1:0] wr_stable;
  logic [ADDR_W-1:0] unread;
  state_t            state_q, state_d;
  grant_t            last_grant, cur_grant, grant_d;
  logic              grant_en;
  logic              pending_stream, pending_peek;
  logic              cap_stream, cap_peek;
  logic              kill_q;
  logic [DATA_W-1:0] tx_data_q, peek_data_q;
  logic              tx_valid_q, peek_done_q;

  ptr_stabilizer #(.ADDR_W(ADDR_W)) u_stab (
    .clk       (CLK100MHZ),
    .reset     (reset),
    .wr_ptr    (wr_ptr),
    .wr_stable (wr_stable)
  );

  assign unread         = wr_stable - rd_ptr;
  assign pending_stream = enable && (wr_stable != rd_ptr) && !tx_valid_q;
  assign pending_peek   = bus.peek_req && !peek_done_q;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    grant_d  = cur_grant;
    case (state_q)
      IDLE: begin
        if (pending_stream || pending_peek) begin
          grant_en = 1'b1;
          state_d  = RD_WAIT;
          if (pending_stream && pending_peek)
            grant_d = (last_grant == GRANT_PEEK) ? GRANT_STREAM : GRANT_PEEK;
          else if (pending_stream)
            grant_d = GRANT_STREAM;
          else
            grant_d = GRANT_PEEK;
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_stream = 1'b0;
    cap_peek   = 1'b0;
    if (state_q == RD_CAP) begin
      cap_stream = (cur_grant == GRANT_STREAM);
      cap_peek   = (cur_grant == GRANT_PEEK);
    end
  end

  // kill_q marks an in-flight stream read that a flush has made stale.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      last_grant  <= GRANT_PEEK;
      cur_grant   <= GRANT_STREAM;
      ram_address <= '0;
      kill_q      <= 1'b0;
      rd_ptr      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      peek_data_q <= '0;
      peek_done_q <= 1'b0;
      level       <= '0;
      near_full   <= 1'b0;
    end else begin
      if (grant_en) begin
        last_grant  <= grant_d;
        cur_grant   <= grant_d;
        ram_address <= (grant_d == GRANT_STREAM) ? rd_ptr : bus.peek_addr;
        kill_q      <= flush;
      end else if (flush) begin
        kill_q <= 1'b1;
      end

      if (flush)
        rd_ptr <= wr_stable;
      else if (cap_stream && !kill_q)
        rd_ptr <= rd_ptr + 1'b1;

      if (flush) begin
        tx_valid_q <= 1'b0;
      end else if (cap_stream && !kill_q) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= ram_data;
      end else if (tx_valid_q && bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      peek_done_q <= cap_peek;
      if (cap_peek) peek_data_q <= ram_data;

      level     <= unread;
      near_full <= (unread >= HW);
    end
  end

  assign state         = state_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.peek_data = peek_data_q;
  assign bus.peek_done = peek_done_q;
endmodule

// File: tb/tb_rx_ram_read_scheduler.sv
// Bench for rx_ram_read_scheduler: RAM model, byte-order scoreboard, peek checks.
module tb_rx_ram_read_scheduler;
  import rx_sched_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int HWM = 192;

  logic          clk = 1'b0;
  logic          reset, enable, flush;
  logic [AW-1:0] wr_ptr, ram_address, level, rd_ptr;
  logic [DW-1:0] ram_data;
  logic          near_full;
  state_t        state;

  rx_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rx_ram_read_scheduler #(.ADDR_W(AW), .DATA_W(DW), .HIGH_WATER(HWM)) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .wr_ptr      (wr_ptr),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .level       (level),
    .near_full   (near_full),
    .state       (state),
    .rd_ptr      (rd_ptr),
    .bus         (bus)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) ram_data <= mem[ram_address];

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] model_wr;
  logic [AW-1:0] peek_exp_addr;
  int            n_vec = 0;
  int            n_err = 0;
  int            last_ev = 0;
  bit            alt_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: accepted stream bytes must come out in write order; peeks return RAM content.
  always @(negedge clk) begin
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) check("tx_unexpected", 32'(exp_q.size()), 32'd1);
      else begin
        check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        if (alt_on && last_ev != 0) check("alternate_s", 32'(last_ev), 32'd2);
        last_ev = 1;
      end
    end
    if (!reset && bus.peek_done) begin
      check("peek_data", 32'(bus.peek_data), 32'(mem[peek_exp_addr]));
      if (alt_on && last_ev != 0 && exp_q.size() > 0) check("alternate_p", 32'(last_ev), 32'd1);
      last_ev = 2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    mem[model_wr] = b;
    exp_q.push_back(b);
    model_wr = model_wr + 1'b1;
    wr_ptr = model_wr;
    ticks(4);
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[model_wr]);
      model_wr = model_wr + 1'b1;
    end
    wr_ptr = model_wr;
    ticks(6);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    int n = 0;
    while (state != s && n < budget) begin tick(); n++; end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_tx_valid(input int budget, input string tag);
    int n = 0;
    while (!bus.tx_valid && n < budget) begin tick(); n++; end
    check(tag, 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.tx_valid || state != IDLE) && n < budget) begin tick(); n++; end
    check(tag, 32'(exp_q.size()), 32'd0);
    ticks(3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_peek, lat, cyc, n_wr, hold;
    logic [AW-1:0] base, exp_addr;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset = 1'b1; enable = 1'b0; flush = 1'b0; wr_ptr = '0; model_wr = '0;
    bus.tx_ready = 1'b0; bus.peek_req = 1'b0; bus.peek_addr = '0; peek_exp_addr = '0;
    ticks(3);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_peek_done", 32'(bus.peek_done), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_peek_data", 32'(bus.peek_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_near_full", 32'(near_full), 32'd0);
    check("rst_ram_address", 32'(ram_address), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // In-order drain of three bytes
    push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hFF);
    ticks(2);
    check("basic_level3", 32'(level), 32'd3);
    enable = 1'b1; bus.tx_ready = 1'b1;
    wait_drain(60, "basic_drain");
    check("basic_level0", 32'(level), 32'd0);
    check("basic_rd_ptr", 32'(rd_ptr), 32'd3);

    // Backpressure: byte held, no further RAM reads
    bus.tx_ready = 1'b0;
    push_byte(8'h11); push_byte(8'h22);
    wait_tx_valid(20, "hold_valid_rise");
    exp_addr = model_wr - 8'd2;
    ticks(10);
    check("hold_valid", 32'(bus.tx_valid), 32'd1);
    check("hold_data", 32'(bus.tx_data), 32'(exp_q[0]));
    check("hold_ram_address", 32'(ram_address), 32'(exp_addr));
    check("hold_state", 32'(state), 32'(IDLE));
    check("hold_level", 32'(level), 32'(exp_q.size() - 1));
    bus.tx_ready = 1'b1;
    wait_drain(60, "hold_drain");
    check("hold_rd_ptr", 32'(rd_ptr), 32'(model_wr));

    // Pointer wrap 254 -> 2
    enable = 1'b0;
    model_wr = 8'd254; wr_ptr = model_wr;
    ticks(6);
    pulse_flush();
    ticks(3);
    check("wrap_rd_ptr", 32'(rd_ptr), 32'd254);
    check("wrap_level0", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    ticks(2);
    check("wrap_level4", 32'(level), 32'd4);
    enable = 1'b1;
    wait_drain(80, "wrap_drain");
    check("wrap_level_end", 32'(level), 32'd0);
    check("wrap_rd_end", 32'(rd_ptr), 32'd2);

    // Peek vs stream arbitration
    enable = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    ticks(2);
    check("arb_level", 32'(level), 32'd6);
    bus.peek_addr = 8'h10; peek_exp_addr = 8'h10; bus.peek_req = 1'b1;
    enable = 1'b1; alt_on = 1'b1; last_ev = 0;
    n_peek = 0; lat = 0; cyc = 0;
    while ((exp_q.size() != 0 || n_peek < 4 || bus.peek_req || bus.tx_valid || state != IDLE) && cyc < 400) begin
      tick(); cyc++; lat++;
      if (bus.peek_done) begin
        n_peek++;
        check("peek_latency_ok", 32'(lat <= 8), 32'd1);
        bus.peek_req = 1'b0;
        tick(); cyc++;
        if (n_peek < 4 || exp_q.size() != 0) begin
          bus.peek_addr = 8'($urandom_range(64, 191));
          peek_exp_addr = bus.peek_addr;
          bus.peek_req = 1'b1;
          lat = 0;
        end
      end
    end
    alt_on = 1'b0;
    check("arb_peeks_done", 32'(n_peek >= 4), 32'd1);
    check("arb_stream_done", 32'(exp_q.size()), 32'd0);
    ticks(3);
    check("arb_rd_ptr", 32'(rd_ptr), 32'(model_wr));
    check("arb_level", 32'(level), 32'd0);

    // Near-full threshold, then flush a held byte
    enable = 1'b0; bus.tx_ready = 1'b0;
    advance(191);
    check("nf_level191", 32'(level), 32'd191);
    check("nf_below", 32'(near_full), 32'd0);
    advance(1);
    check("nf_level192", 32'(level), 32'd192);
    check("nf_at", 32'(near_full), 32'd1);
    enable = 1'b1;
    wait_tx_valid(20, "nf_tx_valid");
    check("nf_tx_data", 32'(bus.tx_data), 32'(exp_q[0]));
    pulse_flush();
    check("flush_tx_valid", 32'(bus.tx_valid), 32'd0);
    ticks(3);
    check("flush_level", 32'(level), 32'd0);
    check("flush_near_full", 32'(near_full), 32'd0);
    check("flush_rd_ptr", 32'(rd_ptr), 32'(model_wr));

    // Flush during an in-flight stream read drops that byte
    enable = 1'b0; bus.tx_ready = 1'b1;
    push_byte(8'($urandom));
    enable = 1'b1;
    wait_state(RD_WAIT, 10, "kill_rd_wait");
    pulse_flush();
    ticks(6);
    check("kill_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("kill_rd_ptr", 32'(rd_ptr), 32'(model_wr));
    check("kill_level", 32'(level), 32'd0);

    // Reset while in RD_WAIT
    enable = 1'b0; bus.tx_ready = 1'b0;
    push_byte(8'($urandom)); push_byte(8'($urandom));
    enable = 1'b1;
    wait_state(RD_WAIT, 10, "rst_rd_wait");
    reset = 1'b1;
    tick();
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("mid_rst_peek_data", 32'(bus.peek_data), 32'd0);
    check("mid_rst_peek_done", 32'(bus.peek_done), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ram_address", 32'(ram_address), 32'd0);
    check("mid_rst_state", 32'(state), 32'(IDLE));
    check("mid_rst_rd_ptr", 32'(rd_ptr), 32'd0);
    model_wr = '0; wr_ptr = '0; exp_q.delete();
    ticks(3);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_no_tx", 32'(bus.tx_valid), 32'd0);
    end

    // Randomized traffic: random writes, backpressure and peeks
    base = model_wr + 8'd150;
    n_wr = 0; hold = 0;
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 800; c++) begin
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      if (hold > 0) hold--;
      else if (n_wr < 100 && $urandom_range(0, 1) == 1) begin
        mem[model_wr] = 8'($urandom);
        exp_q.push_back(mem[model_wr]);
        model_wr = model_wr + 1'b1;
        wr_ptr = model_wr;
        n_wr++;
        hold = $urandom_range(2, 5);
      end
      tick();
      if (bus.peek_done) bus.peek_req = 1'b0;
      else if (!bus.peek_req && $urandom_range(0, 7) == 0) begin
        bus.peek_addr = base + 8'($urandom_range(0, 49));
        peek_exp_addr = bus.peek_addr;
        bus.peek_req = 1'b1;
      end
    end
    bus.peek_req = 1'b0;
    bus.tx_ready = 1'b1;
    wait_drain(800, "rand_drain");
    ticks(4);
    check("rand_level", 32'(level), 32'd0);
    check("rand_rd_ptr", 32'(rd_ptr), 32'(model_wr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the sequence ended");
    $fatal(1, "watchdog");
  end
endmodule
